// File: rtl/pipe_register.sv
// Elastic DEPTH-stage register chain with valid/ready on both sides, bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_register #(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Clr,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [N-1:0]               Data_In,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [N-1:0]               Data_Out,
    output logic [$clog2(DEPTH+1)-1:0] Count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] adv;
    logic [N-1:0]     dat_q [DEPTH];
    logic [N-1:0]     dat_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    // A stage may advance when it is empty or everything downstream of it moves.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = !vld_q[DEPTH-1] | Out_Ready;
        for (int i = DEPTH-2; i >= 0; i--) begin
            adv[i] = !vld_q[i] | adv[i+1];
        end
    end

    assign In_Ready = adv[0] & !Clr;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (adv[0]) begin
            vld_d[0] = In_Valid & In_Ready;
            if (In_Valid) begin
                dat_d[0] = Data_In;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_d[i] = dat_q[i-1];
                end
            end
        end
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(vld_d[i]);
        end
    end

    // Flush clears exactly like reset; data is zeroed so Data_Out reads 0 afterwards.
    always_ff @(posedge Clk) begin
        if (!Reset_n || Clr) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            count_q <= count_d;
        end
    end

    assign Out_Valid = vld_q[DEPTH-1];
    assign Data_Out  = dat_q[DEPTH-1];
    assign Count     = count_q;

endmodule

// File: tb/tb_pipe_register.sv
// Directed vector table on a 16-bit two-stage instance, plus a random run of three
// 8-bit instances (DEPTH 1, 2, 4) against a word-position reference model.
module tb_pipe_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, in_valid, out_ready;
    logic [15:0] din;
    logic        in_ready, out_valid;
    logic [15:0] dout;
    logic [1:0]  count;

    logic        r_clr, r_iv, r_ordy;
    logic [7:0]  r_din;
    logic        r_ir   [3];
    logic        r_ov   [3];
    logic [7:0]  r_dout [3];
    logic [2:0]  r_cnt  [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_register #(.N(16), .DEPTH(2)) dut (
        .Clk(clk), .Reset_n(rst_n), .Clr(clr),
        .In_Valid(in_valid), .In_Ready(in_ready), .Data_In(din),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Data_Out(dout),
        .Count(count)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int D = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        logic [$clog2(D+1)-1:0] cnt;
        pipe_register #(.N(8), .DEPTH(D)) u_dut (
            .Clk(clk), .Reset_n(rst_n), .Clr(r_clr),
            .In_Valid(r_iv), .In_Ready(r_ir[gi]), .Data_In(r_din),
            .Out_Valid(r_ov[gi]), .Out_Ready(r_ordy), .Data_Out(r_dout[gi]),
            .Count(cnt)
        );
        assign r_cnt[gi] = 3'(cnt);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        clr;
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_dout;
        logic        chk_dout;
        logic [1:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(logic c, logic v, logic [15:0] d, logic r,
                                logic eir, logic eov, logic [15:0] ed, logic cd, logic [1:0] ec);
        vec_t t;
        t.clr = c; t.iv = v; t.din = d; t.ordy = r;
        t.e_ir = eir; t.e_ov = eov; t.e_dout = ed; t.chk_dout = cd; t.e_cnt = ec;
        return t;
    endfunction

    function automatic int dep(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // Reference: per instance, the words held (oldest first) and the stage each sits in.
    logic [7:0] mw [3][4];
    int         mp [3][4];
    int         ms [3];

    vec_t vt[$];

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; din = 16'hBEEF; out_ready = 1'b0;
        r_clr = 1'b0; r_iv = 1'b0; r_din = 8'h00; r_ordy = 1'b0;
        for (int k = 0; k < 3; k++) ms[k] = 0;

        // Reset while a word is offered
        @(posedge clk); #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_data_out",  32'(dout),      32'd0);
        chk("reset_count",     32'(count),     32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        chk("reset_no_capture", 32'(count), 32'd0);

        // Stream 1..8 with Out_Ready=1
        vt.push_back(mk(0, 1, 16'h0001, 1, 1, 0, 16'h0, 0, 2'd1));
        for (int k = 2; k <= 8; k++)
            vt.push_back(mk(0, 1, 16'(k), 1, 1, 1, 16'(k-1), 1, 2'd2));
        vt.push_back(mk(0, 0, 16'h0, 1, 1, 1, 16'h0008, 1, 2'd1));
        vt.push_back(mk(0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 2'd0));
        // Back-pressure
        vt.push_back(mk(0, 1, 16'h00A0, 0, 1, 0, 16'h0,    0, 2'd1));
        vt.push_back(mk(0, 1, 16'h00A1, 0, 1, 1, 16'h00A0, 1, 2'd2));
        vt.push_back(mk(0, 1, 16'h00A2, 0, 0, 1, 16'h00A0, 1, 2'd2));
        vt.push_back(mk(0, 1, 16'h00A2, 0, 0, 1, 16'h00A0, 1, 2'd2));
        vt.push_back(mk(0, 1, 16'h00A2, 1, 1, 1, 16'h00A1, 1, 2'd2));
        // Full push+pop
        vt.push_back(mk(0, 1, 16'h0055, 1, 1, 1, 16'h00A2, 1, 2'd2));
        vt.push_back(mk(0, 0, 16'h0,    1, 1, 1, 16'h0055, 1, 2'd1));
        vt.push_back(mk(0, 0, 16'h0,    1, 1, 0, 16'h0,    0, 2'd0));
        // Flush with a word offered
        vt.push_back(mk(0, 1, 16'h00C1, 0, 1, 0, 16'h0,    0, 2'd1));
        vt.push_back(mk(0, 1, 16'h00C2, 0, 1, 1, 16'h00C1, 1, 2'd2));
        vt.push_back(mk(1, 1, 16'h00C3, 0, 0, 0, 16'h0000, 1, 2'd0));
        vt.push_back(mk(0, 0, 16'h0,    1, 1, 0, 16'h0000, 1, 2'd0));
        vt.push_back(mk(0, 0, 16'h0,    1, 1, 0, 16'h0000, 1, 2'd0));

        for (int i = 0; i < vt.size(); i++) begin
            clr = vt[i].clr; in_valid = vt[i].iv; din = vt[i].din; out_ready = vt[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d_count", i),     32'(count),     32'(vt[i].e_cnt));
            if (vt[i].chk_dout)
                chk($sformatf("vec%0d_data_out", i), 32'(dout), 32'(vt[i].e_dout));
            $display("vec %0d: clr=%0b iv=%0b din=%h ordy=%0b -> ov=%0b dout=%h cnt=%0d",
                     i, vt[i].clr, vt[i].iv, vt[i].din, vt[i].ordy, out_valid, dout, count);
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Random run on three depths sharing one input stream
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                int d;
                d = dep(k);
                chk($sformatf("rnd%0d_d%0d_count", cyc, d), 32'(r_cnt[k]), 32'(ms[k]));
                chk($sformatf("rnd%0d_d%0d_out_valid", cyc, d), 32'(r_ov[k]),
                    32'(ms[k] > 0 && mp[k][0] == d - 1));
                if (ms[k] > 0 && mp[k][0] == d - 1)
                    chk($sformatf("rnd%0d_d%0d_data_out", cyc, d), 32'(r_dout[k]), 32'(mw[k][0]));
            end
            r_clr  = ($urandom_range(0, 49) == 0);
            r_iv   = ($urandom_range(0, 9) < 7);
            r_ordy = ($urandom_range(0, 9) < 6);
            r_din  = 8'($urandom);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int  d, lim;
                logic eir, eov;
                d   = dep(k);
                eir = !r_clr && (ms[k] < d || r_ordy);
                eov = ms[k] > 0 && mp[k][0] == d - 1;
                chk($sformatf("rnd%0d_d%0d_in_ready", cyc, d), 32'(r_ir[k]), 32'(eir));
                if (eov && r_ordy) begin
                    for (int j = 1; j < ms[k]; j++) begin
                        mw[k][j-1] = mw[k][j];
                        mp[k][j-1] = mp[k][j];
                    end
                    ms[k]--;
                end
                if (r_clr) begin
                    ms[k] = 0;
                end else begin
                    for (int j = 0; j < ms[k]; j++) begin
                        lim = (j == 0) ? d - 1 : mp[k][j-1] - 1;
                        if (mp[k][j] + 1 <= lim) mp[k][j]++;
                    end
                    if (r_iv && eir) begin
                        mw[k][ms[k]] = r_din;
                        mp[k][ms[k]] = 0;
                        ms[k]++;
                    end
                end
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
